// File: rtl/dmem_responder.sv
// Tagged data-memory responder: accepts one load/store per cycle, hands back a
// tag immediately and completes each request a fixed LATENCY cycles later.
module dmem_responder #(
    parameter int unsigned LATENCY      = 4,
    parameter int unsigned MEM_IDX_BITS = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2Dmem_command,
    input  logic [63:0] proc2Dmem_addr,
    input  logic [63:0] proc2Dmem_data,
    output logic [3:0]  Dmem2proc_response,
    output logic [63:0] Dmem2proc_data,
    output logic [3:0]  Dmem2proc_tag,
    output logic [14:0] dmem_busy_tags
);

    localparam int unsigned NTAGS = 15;
    localparam int unsigned DEPTH = 1 << MEM_IDX_BITS;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2,
        BUS_RSVD  = 2'd3
    } bus_cmd_e;

    bus_cmd_e                cmd;
    logic [63:0]             mem [DEPTH];
    logic [63:0]             slot_data [NTAGS];
    logic [3:0]              count [NTAGS];
    logic [MEM_IDX_BITS-1:0] idx;
    logic                    is_store;
    logic                    is_req;
    logic                    accept;
    logic [3:0]              alloc_tag;
    logic [63:0]             accept_data;
    logic [3:0]              done_tag_next;
    logic [63:0]             done_data_next;
    logic                    unused_addr_bits;

    assign cmd              = bus_cmd_e'(proc2Dmem_command);
    assign idx              = proc2Dmem_addr[MEM_IDX_BITS+2:3];
    assign unused_addr_bits = ^{proc2Dmem_addr[63:MEM_IDX_BITS+3], proc2Dmem_addr[2:0]};
    assign is_store         = (cmd == BUS_STORE);
    assign is_req           = (cmd == BUS_LOAD) || is_store;

    // Allocation looks only at registered occupancy, so a tag freed this cycle waits a cycle.
    always_comb begin
        alloc_tag = '0;
        for (int unsigned i = 0; i < NTAGS; i++) begin
            if (!dmem_busy_tags[i] && alloc_tag == '0) begin
                alloc_tag = 4'(i + 1);
            end
        end
    end

    assign accept             = is_req && !reset && (alloc_tag != '0);
    assign Dmem2proc_response = accept ? alloc_tag : '0;
    assign accept_data        = is_store ? proc2Dmem_data : mem[idx];

    // Counter reads 1 during the completion cycle, so the output register loads
    // from the tag at 2; with LATENCY==1 it loads straight from the accept path.
    always_comb begin
        done_tag_next  = '0;
        done_data_next = '0;
        for (int unsigned i = 0; i < NTAGS; i++) begin
            if (dmem_busy_tags[i] && count[i] == 4'd2) begin
                done_tag_next  = 4'(i + 1);
                done_data_next = slot_data[i];
            end
        end
        if (LATENCY == 1 && accept) begin
            done_tag_next  = alloc_tag;
            done_data_next = accept_data;
        end
    end

    always_ff @(posedge clock) begin
        if (accept && is_store) begin
            mem[idx] <= proc2Dmem_data;
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NTAGS; i++) begin
            if (accept && alloc_tag == 4'(i + 1)) begin
                slot_data[i] <= accept_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dmem_busy_tags <= '0;
            Dmem2proc_tag  <= '0;
            Dmem2proc_data <= '0;
            for (int unsigned i = 0; i < NTAGS; i++) begin
                count[i] <= '0;
            end
        end else begin
            Dmem2proc_tag  <= done_tag_next;
            Dmem2proc_data <= done_data_next;
            for (int unsigned i = 0; i < NTAGS; i++) begin
                if (accept && alloc_tag == 4'(i + 1)) begin
                    dmem_busy_tags[i] <= 1'b1;
                    count[i]          <= 4'(LATENCY);
                end else if (count[i] != '0) begin
                    count[i] <= count[i] - 4'd1;
                    if (count[i] == 4'd1) begin
                        dmem_busy_tags[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Tagged data-memory responder: the memory-side end of the Dmem bus driven by the data-cache controller.
- Accepts one BUS_LOAD/BUS_STORE command per cycle and returns an allocated tag on Dmem2proc_response in the same cycle.
- Completes each accepted request exactly LATENCY cycles later by presenting Dmem2proc_tag with Dmem2proc_data.
- Serves as the synthesizable memory model behind the dcache for system simulation and bus-protocol verification.

Parameters:
- LATENCY, 4: cycles from accept to completion; legal range 1..15.
- MEM_IDX_BITS, 10: log2 of backing-store depth in 64-bit words (1024 words).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- proc2Dmem_command  input  2  0=BUS_NONE, 1=BUS_LOAD, 2=BUS_STORE, 3=treated as BUS_NONE.
- proc2Dmem_addr  input  64  byte address; word index = addr[MEM_IDX_BITS+2:3]; all other bits ignored.
- proc2Dmem_data  input  64  store data.
- Dmem2proc_response  output  4  combinational; allocated tag 1..15 when the command is accepted this cycle, else 0.
- Dmem2proc_data  output  64  registered; completion data (load: read word; store: written word).
- Dmem2proc_tag  output  4  registered; tag completing this cycle, 0 when none.
- dmem_busy_tags  output  15  registered occupancy vector; bit i-1 set means tag i is outstanding.

Behaviour:
- Reset:
  - All tags free; Dmem2proc_tag=0; Dmem2proc_data=0; dmem_busy_tags=0; all countdown counters cleared.
  - Backing-store contents are unaffected by reset.
  - Requests in flight when reset asserts are dropped with no completion.
- Accept (combinational, cycle t):
  - A command is accepted if it is LOAD or STORE, reset is low, and at least one tag is free.
  - The lowest-numbered free tag is driven on Dmem2proc_response. Otherwise Dmem2proc_response=0 and the command is ignored; the initiator retries.
- At posedge ending cycle t, for an accepted command:
  - The tag is marked busy and its counter is loaded with LATENCY.
  - LOAD: mem[idx] is snapshotted into that tag's data slot.
  - STORE: mem[idx] is written with proc2Dmem_data, and the same value goes into the data slot.
- Completion:
  - Each busy tag's counter decrements every cycle.
  - During cycle t+LATENCY, Dmem2proc_tag=that tag and Dmem2proc_data=its slot. Both are registered from the posedge starting that cycle.
  - The tag is freed at the posedge ending cycle t+LATENCY and is allocatable from cycle t+LATENCY+1.
- At most one completion per cycle: fixed latency with one accept per cycle guarantees uniqueness. When nothing completes, Dmem2proc_tag=0 and Dmem2proc_data holds 0.
- Ordering:
  - A store accepted in cycle t is visible to a load accepted in cycle t+1 or later.
  - A load accepted before a store to the same word returns the old value.
  - Completion order equals accept order.
- Full condition: with LATENCY<15 the 15 tags never exhaust under one accept per cycle. The full check (response 0) is still required.
- Simultaneous accept and free in the same cycle: the freed tag is not reusable until the next cycle. Allocation uses registered occupancy only.
- Address wrap: indices beyond the store depth alias modulo 2^MEM_IDX_BITS.
- Tag 0 is never allocated or completed.

Test Plan:
- Reset, then idle 10 cycles -> Dmem2proc_response=0, Dmem2proc_tag=0, Dmem2proc_data=0, dmem_busy_tags=0 throughout.
- STORE addr 0x40 data 0xDEADBEEF_CAFEF00D in cycle 0 -> response=1 in cycle 0; cycle 4 tag=1, data=0xDEADBEEF_CAFEF00D; busy bit 0 clears in cycle 5.
- STORE 0x40=0x11 in cycle 0, LOAD 0x40 in cycle 1 -> load gets response=2; cycle 5 tag=2, data=0x11.
- LOAD 0x80 (old value 0x5) in cycle 0, STORE 0x80=0x9 in cycle 1 -> cycle 4 tag=1, data=0x5; cycle 5 tag=2, data=0x9.
- LATENCY=15, back-to-back LOADs cycles 0..15 -> tags 1..15 in cycles 0..14. Cycle 15 response=0 (full, ignored). Cycle 16 allocates tag 1.
- 3 in-flight LOADs, reset asserted in cycle 2 -> no Dmem2proc_tag≠0 after reset; a LOAD issued after reset deasserts gets response=1.
